// File: rtl/cpu_run_controller.sv
// Run controller: conditions the pushbutton and decides in which cycles the
// CPU may advance one instruction (free-run, single-step, breakpoint, halt).
module cpu_run_controller #(
    parameter int PC_WIDTH          = 8,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int CYCLE_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         isReset,
    input  logic                         switch,
    input  logic                         runMode,
    input  logic                         breakEnable,
    input  logic [PC_WIDTH-1:0]          breakAddress,
    input  logic [PC_WIDTH-1:0]          programCounter,
    input  logic                         haltRequest,
    output logic                         cpuEnable,
    output logic                         isHalted,
    output logic                         isAtBreak,
    output logic [CYCLE_COUNT_WIDTH-1:0] cycleCount,
    output logic [1:0]                   state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CYCLE_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic            sync_a;
    logic            sync_b;
    logic            clean_level;
    logic [DB_W-1:0] db_count;
    logic            press_pulse;
    logic            first_cycle;
    logic            halted;
    logic            at_break;
    logic            break_hit;

    // The clean level only follows the synchronized input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clock) begin
        if (isReset) begin
            sync_a      <= 1'b0;
            sync_b      <= 1'b0;
            clean_level <= 1'b0;
            db_count    <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_a      <= switch;
            sync_b      <= sync_a;
            press_pulse <= 1'b0;
            if (sync_b != clean_level) begin
                if (db_count == DB_LAST) begin
                    clean_level <= sync_b;
                    db_count    <= '0;
                    press_pulse <= sync_b;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    // The first RUN cycle after a resume must execute the breakpoint instruction.
    assign break_hit = breakEnable && (programCounter == breakAddress) && !first_cycle;

    always_comb begin
        cpuEnable = 1'b0;
        if (state == RUN) begin
            cpuEnable = !haltRequest && !break_hit;
        end else if (state == STEP) begin
            cpuEnable = !haltRequest;
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            state       <= IDLE;
            first_cycle <= 1'b0;
            halted      <= 1'b0;
            at_break    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_pulse) begin
                        at_break <= 1'b0;
                        if (runMode) begin
                            state       <= RUN;
                            first_cycle <= 1'b1;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                RUN: begin
                    first_cycle <= 1'b0;
                    if (haltRequest) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (break_hit) begin
                        state    <= IDLE;
                        at_break <= 1'b1;
                    end else if (press_pulse) begin
                        state <= IDLE;
                    end
                end
                STEP: begin
                    if (haltRequest) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            cycleCount <= '0;
        end else if (cpuEnable && (cycleCount != COUNT_MAX)) begin
            cycleCount <= cycleCount + 1'b1;
        end
    end

    assign isHalted  = halted;
    assign isAtBreak = at_break;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: debounce, step, breakpoint, halt,
// counter saturation and reset during a press.
module tb_cpu_run_controller;

    logic        clock = 1'b0;
    logic        rst;
    logic        sw;
    logic        run_mode;
    logic        break_en;
    logic [7:0]  break_addr;
    logic [7:0]  pc;
    logic        halt_arm;
    logic        halt_req;
    logic        cpu_enable;
    logic        is_halted;
    logic        is_at_break;
    logic [15:0] cycle_count;
    logic [1:0]  state;

    logic        rst_sat;
    logic        sw_sat;
    logic        en_sat;
    logic        halted_sat;
    logic        brk_sat;
    logic [3:0]  count_sat;
    logic [1:0]  state_sat;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_run_controller #(.PC_WIDTH(8), .DEBOUNCE_CYCLES(4), .CYCLE_COUNT_WIDTH(16)) dut (
        .clock(clock), .isReset(rst), .switch(sw), .runMode(run_mode),
        .breakEnable(break_en), .breakAddress(break_addr), .programCounter(pc),
        .haltRequest(halt_req), .cpuEnable(cpu_enable), .isHalted(is_halted),
        .isAtBreak(is_at_break), .cycleCount(cycle_count), .state(state)
    );

    cpu_run_controller #(.PC_WIDTH(8), .DEBOUNCE_CYCLES(4), .CYCLE_COUNT_WIDTH(4)) dut_sat (
        .clock(clock), .isReset(rst_sat), .switch(sw_sat), .runMode(1'b1),
        .breakEnable(1'b0), .breakAddress(8'h00), .programCounter(8'h00),
        .haltRequest(1'b0), .cpuEnable(en_sat), .isHalted(halted_sat),
        .isAtBreak(brk_sat), .cycleCount(count_sat), .state(state_sat)
    );

    // Simple CPU model: PC advances once per enabled cycle, HALT decoded at 0x05.
    always @(posedge clock) begin
        if (rst) pc <= 8'h00;
        else if (cpu_enable) pc <= pc + 8'h01;
    end
    assign halt_req = halt_arm && (pc == 8'h05);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input int hold);
        sw = 1'b1;
        repeat (hold) tick();
        sw = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; sw = 1'b0; run_mode = 1'b0; break_en = 1'b0;
        break_addr = 8'h00; halt_arm = 1'b0; rst_sat = 1'b1; sw_sat = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rst_sat = 1'b0;
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_en", 32'(cpu_enable), 32'd0);
        check("reset_count", 32'(cycle_count), 32'd0);
        check("reset_halted", 32'(is_halted), 32'd0);
        check("reset_break", 32'(is_at_break), 32'd0);

        // 3-cycle glitch must be filtered out
        press(3);
        n = 0;
        repeat (15) begin
            tick();
            if (cpu_enable) n++;
        end
        check("glitch_state", 32'(state), 32'd0);
        check("glitch_en_cycles", 32'(n), 32'd0);
        check("glitch_count", 32'(cycle_count), 32'd0);

        // single step: enable exactly at the 7th tick after the switch rises
        run_mode = 1'b0;
        sw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("step_en_t%0d", i), 32'(cpu_enable), 32'(i == 7));
            if (i == 7) check("step_state", 32'(state), 32'd2);
        end
        repeat (8) tick();
        sw = 1'b0;
        repeat (10) tick();
        check("step1_count", 32'(cycle_count), 32'd1);
        check("step1_state", 32'(state), 32'd0);
        press(20);
        repeat (10) tick();
        check("step2_count", 32'(cycle_count), 32'd2);
        check("step2_state", 32'(state), 32'd0);

        // breakpoint at 0x10
        do_reset();
        run_mode = 1'b1; break_en = 1'b1; break_addr = 8'h10;
        press(8);
        n = 0;
        while (!(state == 2'd0 && is_at_break) && n < 60) begin
            tick();
            n++;
        end
        check("break_timeout", 32'(n < 60), 32'd1);
        check("break_pc", 32'(pc), 32'h10);
        check("break_flag", 32'(is_at_break), 32'd1);
        check("break_state", 32'(state), 32'd0);
        check("break_count", 32'(cycle_count), 32'd16);
        check("break_en", 32'(cpu_enable), 32'd0);
        press(8);
        n = 0;
        while (pc != 8'h12 && n < 30) begin
            tick();
            n++;
        end
        check("resume_timeout", 32'(n < 30), 32'd1);
        check("resume_flag", 32'(is_at_break), 32'd0);
        check("resume_state", 32'(state), 32'd1);
        check("resume_count", 32'(cycle_count), 32'd18);

        // halt decoded at PC 0x05
        do_reset();
        break_en = 1'b0; halt_arm = 1'b1; run_mode = 1'b1;
        press(8);
        n = 0;
        while (pc != 8'h05 && n < 40) begin
            tick();
            n++;
        end
        check("halt_timeout", 32'(n < 40), 32'd1);
        check("halt_en_low", 32'(cpu_enable), 32'd0);
        check("halt_pre_state", 32'(state), 32'd1);
        tick();
        check("halt_state", 32'(state), 32'd3);
        check("halt_flag", 32'(is_halted), 32'd1);
        check("halt_count", 32'(cycle_count), 32'd5);
        press(10);
        repeat (15) tick();
        check("halt_press_state", 32'(state), 32'd3);
        check("halt_press_count", 32'(cycle_count), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_en", 32'(cpu_enable), 32'd0);
        check("halt_rst_flag", 32'(is_halted), 32'd0);
        check("halt_rst_break", 32'(is_at_break), 32'd0);
        check("halt_rst_count", 32'(cycle_count), 32'd0);
        halt_arm = 1'b0;

        // 4-bit counter saturates
        sw_sat = 1'b1;
        repeat (8) tick();
        sw_sat = 1'b0;
        repeat (25) tick();
        check("sat_count", 32'(count_sat), 32'd15);
        check("sat_state", 32'(state_sat), 32'd1);
        check("sat_en", 32'(en_sat), 32'd1);

        // reset lands on the edge where a pause press would be acted on
        do_reset();
        run_mode = 1'b1;
        press(8);
        n = 0;
        while (state != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        check("mid_run_timeout", 32'(n < 20), 32'd1);
        repeat (4) tick();
        sw = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        sw = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_en", 32'(cpu_enable), 32'd0);
        repeat (15) tick();
        check("mid_rst_state_late", 32'(state), 32'd0);
        check("mid_rst_count", 32'(cycle_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
